fadd_sched: RTL and testbench
=============================

Name: fadd_sched

Overview:
- Round-robin issue scheduler sharing one fully pipelined fadd datapath between NREQ requesters, e.g. FP issue ports or the fadd self-test sequencer.
- Each cycle it grants at most one request and registers that request's operands and controls onto the fadd inputs.
- It tracks the in-flight operation through a valid/ID shift pipe matched to the fadd latency and returns each result tagged with the originating requester ID.
- A flush input kills all in-flight operations.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ.
- FW, 81, operand/result width (hidden-bit flag plus 80-bit extended value).
- LAT, 2, fadd latency in cycles, from fa_* inputs stable to fa_res valid; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_vld  in  NREQ  per-requester request valid
- req_rdy  out  NREQ  per-requester grant; one-hot or zero
- req_A  in  NREQ*FW  operand A, requester i at [i*FW +: FW]
- req_B  in  NREQ*FW  operand B, same packing as req_A
- req_isDBL  in  NREQ  1 = double precision, 0 = extended
- req_isSub  in  NREQ  subtract (includes reverse subtract)
- req_rmode  in  NREQ*3  rounding mode
- flush  in  1  kill all in-flight operations
- fa_A  out  FW  to fadd A
- fa_B  out  FW  to fadd B
- fa_isDBL  out  1  to fadd isDBL
- fa_isSub  out  1  to fadd isSub
- fa_rmode  out  3  to fadd rmode
- fa_res  in  FW  from fadd res
- res_vld  out  1  result valid
- res_id  out  IDW  requester ID of the result
- res  out  FW  result data; equals fa_res
- idle  out  1  no operation issued or in flight

Behaviour:
- Reset: rst is synchronous, active-high.
  - Clears the RR pointer to 0, the issue-valid register, all tag-pipe valid bits and the in-flight counter.
  - Zeroes fa_A, fa_B, fa_isDBL, fa_isSub, fa_rmode and res_id.
  - During reset and the cycle it is deasserted: res_vld=0, req_rdy=0, idle=1.
- Arbitration is combinational.
  - Grant goes to the first i with req_vld[i]=1, scanning ptr, ptr+1, … modulo NREQ.
  - req_rdy = one-hot grant; 0 when rst or flush is high.
  - A request is accepted at a clock edge where req_vld[i]&req_rdy[i]=1.
  - Requesters hold operands stable while req_vld=1 and not yet granted.
- Pointer: on acceptance from requester g, ptr <= (g+1) mod NREQ. Otherwise ptr holds.
- Issue stage:
  - On acceptance at edge T, register the operands and controls into fa_*. Issue-valid and ID enter the tag pipe stage 0.
  - fa_* are valid during cycle T+1.
  - With no acceptance, fa_* hold their previous values (power saving) and stage-0 valid = 0.
- Tag pipe: LAT+1 stages of {valid, id}, advancing every cycle with no stall.
  - The last stage aligns with fa_res for the op issued at T.
  - res_vld=1, res_id=id and res=fa_res occur in cycle T+1+LAT (combinational from the last stage). With LAT=2, a request accepted at edge 0 returns in cycle 3.
  - Results return in issue order. Back-to-back issue is allowed every cycle, so throughput is 1 op/cycle.
- Result port: res has no backpressure; requesters must always accept.
- Flush:
  - At the edge where flush=1, clear every tag-pipe valid bit and the in-flight counter. No acceptance occurs that cycle.
  - res_vld is forced 0 during the flush cycle.
  - ptr is unchanged.
  - Results of killed ops never appear.
- In-flight counter, width clog2(LAT+2):
  - Increments on acceptance and decrements on res_vld.
  - Net 0 when both happen in the same cycle.
  - idle = (count==0) and no req_vld; idle is informational only.
- Simultaneous events: rst has priority over flush, and flush over acceptance.
- NREQ=1 degenerates to a pass-through with ptr fixed at 0.

Test Plan:
- Single op (LAT=2):
  - Stimulus: after reset, req_vld=0001, A=81'h1_3FFF_8000000000000000 (1.0 ext), B = same, isSub=0, rmode=2, accepted at edge 0.
  - Required: res_vld=1, res_id=0, res=81'h1_4000_8000000000000000 (2.0) in cycle 3 only.
- Round-robin fairness:
  - Stimulus: req_vld=1111 held for 8 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3; res_id sequence identical, shifted 3 cycles; one result per cycle.
- Pointer skip:
  - Stimulus: ptr=1, req_vld=1001.
  - Required: grant to 3, then 0, then ptr=1.
- Flush:
  - Stimulus: issue ops from req 1 and req 2 on consecutive edges; flush=1 one cycle after the second acceptance.
  - Required: neither result appears (res_vld stays 0); idle=1 after flush; a new op issued after flush returns normally.
- Mid-operation reset:
  - Stimulus: rst=1 with 3 ops in flight.
  - Required: res_vld=0 for all following cycles until new issue; ptr=0; fa_* = 0.
- Golden vectors:
  - Stimulus: stream fadd16e memh vectors through requesters 0..3 cyclically, with random req_vld gaps.
  - Required: every res matches the expected result for its res_id, in issue order.

Source files
------------

// File: rtl/fadd_sched.sv
// Round-robin issue scheduler sharing one pipelined fadd among NREQ requesters.
// Latency: accepted at edge T, result tagged in cycle T+1+LAT; no backpressure on results.
module fadd_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int FW   = 81,
  parameter int LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_vld,
  output logic [NREQ-1:0]   req_rdy,
  input  logic [NREQ*FW-1:0] req_A,
  input  logic [NREQ*FW-1:0] req_B,
  input  logic [NREQ-1:0]   req_isDBL,
  input  logic [NREQ-1:0]   req_isSub,
  input  logic [NREQ*3-1:0] req_rmode,
  input  logic              flush,
  output logic [FW-1:0]     fa_A,
  output logic [FW-1:0]     fa_B,
  output logic              fa_isDBL,
  output logic              fa_isSub,
  output logic [2:0]        fa_rmode,
  input  logic [FW-1:0]     fa_res,
  output logic              res_vld,
  output logic [IDW-1:0]    res_id,
  output logic [FW-1:0]     res,
  output logic              idle
);

  localparam int CW = $clog2(LAT + 2);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gnt_id;
  logic           gnt_any;
  logic           accept;
  int             arb_idx;

  logic [FW-1:0]  fa_a_q, fa_b_q;
  logic           fa_dbl_q, fa_sub_q;
  logic [2:0]     fa_rm_q;

  logic [LAT:0]   vld_q;
  logic [IDW-1:0] id_q [LAT+1];
  logic [CW-1:0]  cnt_q, cnt_d;

  // Scan from the far end back toward ptr so the nearest requester wins last.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    arb_idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      arb_idx = (int'(ptr_q) + k) % NREQ;
      if (req_vld[arb_idx]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(arb_idx);
      end
    end
    accept  = gnt_any & ~rst & ~flush;
    req_rdy = accept ? (NREQ'(1) << gnt_id) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  assign res_vld = vld_q[LAT] & ~rst & ~flush;
  assign res_id  = id_q[LAT];
  assign res     = fa_res;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (accept && !res_vld) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!accept && res_vld) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign idle = rst | ((cnt_q == '0) & ~|req_vld);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      fa_a_q   <= '0;
      fa_b_q   <= '0;
      fa_dbl_q <= 1'b0;
      fa_sub_q <= 1'b0;
      fa_rm_q  <= '0;
      vld_q    <= '0;
      cnt_q    <= '0;
      for (int k = 0; k <= LAT; k++) id_q[k] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      // Operand registers only load on a grant so the datapath inputs stay quiet otherwise.
      if (accept) begin
        fa_a_q   <= req_A[int'(gnt_id)*FW +: FW];
        fa_b_q   <= req_B[int'(gnt_id)*FW +: FW];
        fa_dbl_q <= req_isDBL[gnt_id];
        fa_sub_q <= req_isSub[gnt_id];
        fa_rm_q  <= req_rmode[int'(gnt_id)*3 +: 3];
      end
      vld_q   <= flush ? '0 : {vld_q[LAT-1:0], accept};
      id_q[0] <= gnt_id;
      for (int k = 1; k <= LAT; k++) id_q[k] <= id_q[k-1];
    end
  end

  assign fa_A     = fa_a_q;
  assign fa_B     = fa_b_q;
  assign fa_isDBL = fa_dbl_q;
  assign fa_isSub = fa_sub_q;
  assign fa_rmode = fa_rm_q;

endmodule

// File: tb/tb_fadd_sched.sv
// Bench for fadd_sched: directed scenarios then randomized traffic with flushes,
// checked cycle by cycle against a queue-based round-robin and result-order model.
module tb_fadd_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int FW   = 81;
  localparam int LAT  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, flush;
  logic [NREQ-1:0]    req_vld, req_rdy, req_isDBL, req_isSub;
  logic [NREQ*FW-1:0] req_A, req_B;
  logic [NREQ*3-1:0]  req_rmode;
  logic [FW-1:0]      fa_A, fa_B, fa_res, res;
  logic               fa_isDBL, fa_isSub, res_vld, idle;
  logic [2:0]         fa_rmode;
  logic [IDW-1:0]     res_id;

  logic [FW-1:0] op_a [NREQ];
  logic [FW-1:0] op_b [NREQ];
  logic [FW-1:0] op_e [NREQ];
  logic          op_dbl [NREQ];
  logic          op_sub [NREQ];
  logic [2:0]    op_rm [NREQ];

  always_comb begin
    req_A = '0; req_B = '0; req_rmode = '0; req_isDBL = '0; req_isSub = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_A[i*FW +: FW]  = op_a[i];
      req_B[i*FW +: FW]  = op_b[i];
      req_rmode[i*3 +: 3] = op_rm[i];
      req_isDBL[i] = op_dbl[i];
      req_isSub[i] = op_sub[i];
    end
  end

  fadd_sched #(.NREQ(NREQ), .IDW(IDW), .FW(FW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_A(req_A), .req_B(req_B), .req_isDBL(req_isDBL), .req_isSub(req_isSub),
    .req_rmode(req_rmode), .flush(flush),
    .fa_A(fa_A), .fa_B(fa_B), .fa_isDBL(fa_isDBL), .fa_isSub(fa_isSub),
    .fa_rmode(fa_rmode), .fa_res(fa_res),
    .res_vld(res_vld), .res_id(res_id), .res(res), .idle(idle)
  );

  // Stand-in datapath: exact for x+x on normal extended values, a keyed mix otherwise.
  function automatic logic [FW-1:0] fadd_f(logic [FW-1:0] a, logic [FW-1:0] b,
                                           logic dbl, logic sub, logic [2:0] rm);
    if (!sub && a == b && a[78:64] != 15'h0 && a[78:64] < 15'h7FFE)
      return {a[80:79], a[78:64] + 15'd1, a[63:0]};
    return a ^ {b[39:0], b[80:40]} ^ {76'd0, dbl, sub, rm};
  endfunction

  logic [FW-1:0] p1, p2;
  always @(posedge clk) begin
    p1 <= fadd_f(fa_A, fa_B, fa_isDBL, fa_isSub, fa_rmode);
    p2 <= p1;
  end
  assign fa_res = p2;

  logic [FW-1:0] g_a [6];
  logic [FW-1:0] g_e [6];
  initial begin
    g_a[0] = 81'h1_3FFF_8000_0000_0000_0000; g_e[0] = 81'h1_4000_8000_0000_0000_0000;
    g_a[1] = 81'h1_3FFF_C000_0000_0000_0000; g_e[1] = 81'h1_4000_C000_0000_0000_0000;
    g_a[2] = 81'h1_4000_C000_0000_0000_0000; g_e[2] = 81'h1_4001_C000_0000_0000_0000;
    g_a[3] = 81'h1_C000_8000_0000_0000_0000; g_e[3] = 81'h1_C001_8000_0000_0000_0000;
    g_a[4] = 81'h1_3FFE_C000_0000_0000_0000; g_e[4] = 81'h1_3FFF_C000_0000_0000_0000;
    g_a[5] = 81'h1_4002_A000_0000_0000_0000; g_e[5] = 81'h1_4003_A000_0000_0000_0000;
  end

  typedef struct packed {
    int             due;
    logic [IDW-1:0] id;
    logic [FW-1:0]  d;
  } exp_t;

  exp_t          pend [$];
  int            checks = 0, errors = 0;
  int            cyc = 0, m_ptr = 0, last_g = -1, gk = 0;
  logic [FW-1:0] m_fa_a = '0, m_fa_b = '0;
  logic          m_fa_dbl = 1'b0, m_fa_sub = 1'b0;
  logic [2:0]    m_fa_rm = '0;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int rr(int ptr, logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic load(input int i, input bit golden);
    logic [95:0] r;
    if (golden) begin
      op_a[i] = g_a[gk]; op_b[i] = g_a[gk]; op_e[i] = g_e[gk];
      op_sub[i] = 1'b0; op_dbl[i] = 1'b0; op_rm[i] = 3'($urandom_range(0, 4));
      gk = (gk + 1) % 6;
    end else begin
      r = {$urandom, $urandom, $urandom}; op_a[i] = r[FW-1:0];
      r = {$urandom, $urandom, $urandom}; op_b[i] = r[FW-1:0];
      if ($urandom_range(0, 3) == 0) op_b[i] = op_a[i];
      op_dbl[i] = 1'($urandom); op_sub[i] = 1'($urandom); op_rm[i] = 3'($urandom);
      op_e[i] = fadd_f(op_a[i], op_b[i], op_dbl[i], op_sub[i], op_rm[i]);
    end
  endtask

  // Check one cycle mid-period, then advance the model across the next edge.
  task automatic tick();
    int g;
    logic [NREQ-1:0] eg;
    bit ev;
    exp_t e;
    #4;
    g  = (rst || flush) ? -1 : rr(m_ptr, req_vld);
    eg = (g < 0) ? '0 : (NREQ'(1) << g);
    chk("req_rdy", FW'(req_rdy), FW'(eg));
    ev = !rst && !flush && pend.size() > 0 && pend[0].due == cyc;
    chk("res_vld", FW'(res_vld), FW'(ev));
    if (ev) begin
      chk("res_id", FW'(res_id), FW'(pend[0].id));
      chk("res", res, pend[0].d);
    end
    chk("idle", FW'(idle), FW'(rst || (pend.size() == 0 && req_vld == '0)));
    chk("fa_A", fa_A, m_fa_a);
    chk("fa_B", fa_B, m_fa_b);
    chk("fa_ctl", FW'({fa_isDBL, fa_isSub, fa_rmode}), FW'({m_fa_dbl, m_fa_sub, m_fa_rm}));
    if (rst) begin
      m_ptr = 0; pend.delete();
      m_fa_a = '0; m_fa_b = '0; m_fa_dbl = 1'b0; m_fa_sub = 1'b0; m_fa_rm = '0;
    end else if (flush) begin
      pend.delete();
    end else begin
      if (ev) void'(pend.pop_front());
      if (g >= 0) begin
        e.due = cyc + 1 + LAT; e.id = IDW'(g); e.d = op_e[g];
        pend.push_back(e);
        m_fa_a = op_a[g]; m_fa_b = op_b[g]; m_fa_dbl = op_dbl[g];
        m_fa_sub = op_sub[g]; m_fa_rm = op_rm[g];
        m_ptr = (g + 1) % NREQ;
      end
    end
    last_g = g;
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_vld = '0;
    for (int i = 0; i < NREQ; i++) load(i, 1'b0);
    @(posedge clk); #1;

    // Reset state, then a lone 1.0 + 1.0 from requester 0
    repeat (3) tick();
    rst = 1'b0;
    tick();
    load(0, 1'b1); op_rm[0] = 3'd2;
    req_vld = 4'b0001; tick();
    req_vld = '0; repeat (5) tick();

    // Fairness from ptr 0: all requesters held high for 8 cycles
    rst = 1'b1; tick(); rst = 1'b0; tick();
    req_vld = 4'b1111;
    repeat (8) begin
      tick();
      if (last_g >= 0) load(last_g, 1'b0);
    end
    req_vld = '0; repeat (4) tick();

    // Pointer skip: move ptr to 1, then requesters 3 and 0 contend
    load(0, 1'b0); req_vld = 4'b0001; tick();
    req_vld = 4'b1001; tick();
    if (last_g >= 0) req_vld[last_g] = 1'b0;
    tick();
    req_vld = '0; repeat (4) tick();

    // Flush kills two back-to-back ops, then a fresh op completes
    req_vld = 4'b0010; tick();
    req_vld = 4'b0100; tick();
    req_vld = 4'b0000; flush = 1'b1; tick();
    flush = 1'b0; repeat (4) tick();
    req_vld = 4'b1000; flush = 1'b1; tick();
    flush = 1'b0; tick();
    req_vld = '0; repeat (4) tick();

    // Reset with three ops in flight
    req_vld = 4'b1111; repeat (3) tick();
    req_vld = '0; rst = 1'b1; tick();
    rst = 1'b0; repeat (5) tick();

    // Randomized traffic: golden vectors first, then random operands, sporadic flushes
    for (int n = 0; n < 300; n++) begin
      flush = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_vld[i] && $urandom_range(0, 2) == 0) begin
          load(i, n < 80);
          req_vld[i] = 1'b1;
        end
      end
      tick();
      if (last_g >= 0) req_vld[last_g] = 1'b0;
    end
    flush = 1'b0; req_vld = '0;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
